// File: rtl/core_pkg.sv
// Shared encodings for the write-back stage: L1D request fields,
// load extension types, result mux selects and the WB FSM states.
package core_pkg;

   localparam logic [1:0] COP_LOAD  = 2'b00;
   localparam logic [1:0] COP_STORE = 2'b01;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   localparam logic [2:0] SX_LB  = 3'b000;
   localparam logic [2:0] SX_LH  = 3'b001;
   localparam logic [2:0] SX_LW  = 3'b010;
   localparam logic [2:0] SX_LBU = 3'b100;
   localparam logic [2:0] SX_LHU = 3'b101;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_LD  = 2'b01;
   localparam logic [1:0] MUX_IMM = 2'b10;
   localparam logic [1:0] MUX_PC4 = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_RESP = 2'b10,
      S_DONE = 2'b11
   } wb_state_e;

   // Store data is replicated across every lane the access could hit.
   function automatic logic [31:0] st_repl(input logic [31:0] d,
                                           input logic [2:0]  sz);
      logic [31:0] r;
      case (sz)
         SZ_BYTE: r = {4{d[7:0]}};
         SZ_HALF: r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/core_wb_ldext.sv
// Load lane extraction and sign/zero extension.
// Lane chosen from the low address bits; alignment is not checked.
module core_wb_ldext
   import core_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  sx_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   always_comb begin
      byte_w = rdata_i[8*off_i +: 8];
      half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (sx_i)
         SX_LB:   data_o = {{24{byte_w[7]}}, byte_w};
         SX_LH:   data_o = {{16{half_w[15]}}, half_w};
         SX_LBU:  data_o = {24'h0, byte_w};
         SX_LHU:  data_o = {16'h0, half_w};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/core_wb_s.sv
// Write-back stage: issues L1D requests, stalls upstream while
// the access is outstanding, and drives the register-file write.
module core_wb_s
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_kill,
   input  logic        wb_l1d_req_val_in,
   input  logic [2:0]  wb_l1d_req_cop_in,
   input  logic [2:0]  wb_l1d_req_size_in,
   input  logic [31:0] wb_alu_result_in,
   input  logic [31:0] wb_wrt_data_in,
   input  logic [31:0] wb_sx_imm_in,
   input  logic [31:0] wb_pc_4_in,
   input  logic        wb_we_reg_file_in,
   input  logic [1:0]  wb_mux_in,
   input  logic [2:0]  wb_sx_type_in,
   input  logic [4:0]  wb_rd_in,
   output logic        l1d_req_val,
   input  logic        l1d_req_ack,
   output logic [31:0] l1d_req_addr,
   output logic [2:0]  l1d_req_cop,
   output logic [2:0]  l1d_req_size,
   output logic [31:0] l1d_req_wdata,
   input  logic        l1d_resp_val,
   input  logic [31:0] l1d_resp_rdata,
   output logic        wb2rf_we,
   output logic [4:0]  wb2rf_rd,
   output logic [31:0] wb2rf_data,
   output logic [31:0] wb2mem_bp_data,
   output logic        wb2haz_stall
);

   wb_state_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  cop_q, cop_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  sx_q, sx_d;
   logic [4:0]  rd_q, rd_d;
   logic        kill_q, kill_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_data_q, rf_data_d;

   logic [31:0] ld_data;
   logic [31:0] res_data;
   logic        killed;
   logic        is_store;

   core_wb_ldext u_ldext (
      .rdata_i (l1d_resp_rdata),
      .off_i   (addr_q[1:0]),
      .sx_i    (sx_q),
      .data_o  (ld_data)
   );

   always_comb begin
      case (wb_mux_in)
         MUX_ALU: res_data = wb_alu_result_in;
         MUX_LD:  res_data = ld_data;
         MUX_IMM: res_data = wb_sx_imm_in;
         default: res_data = wb_pc_4_in;
      endcase
   end

   assign killed   = kill_q | wb_kill;
   assign is_store = (cop_q[1:0] == COP_STORE);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cop_d     = cop_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      sx_d      = sx_q;
      rd_d      = rd_q;
      kill_d    = kill_q;
      rf_we_d   = 1'b0;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (wb_l1d_req_val_in && !wb_kill) begin
               addr_d  = wb_alu_result_in;
               cop_d   = wb_l1d_req_cop_in;
               size_d  = wb_l1d_req_size_in;
               wdata_d = st_repl(wb_wrt_data_in, wb_l1d_req_size_in);
               sx_d    = wb_sx_type_in;
               rd_d    = wb_rd_in;
               kill_d  = 1'b0;
               state_d = S_REQ;
            end else if (!wb_l1d_req_val_in && wb_we_reg_file_in &&
                         !wb_kill && (wb_rd_in != 5'd0)) begin
               rf_we_d   = 1'b1;
               rf_rd_d   = wb_rd_in;
               rf_data_d = res_data;
            end
         end
         S_REQ: begin
            // Once acked the access is in flight; a kill only mutes it.
            if (l1d_req_ack) begin
               kill_d  = killed;
               state_d = is_store ? S_DONE : S_RESP;
            end else if (wb_kill) begin
               state_d = S_IDLE;
            end
         end
         S_RESP: begin
            kill_d = killed;
            if (l1d_resp_val) begin
               state_d = S_DONE;
               if (!killed && (rd_q != 5'd0)) begin
                  rf_we_d   = 1'b1;
                  rf_rd_d   = rd_q;
                  rf_data_d = ld_data;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cop_q     <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         sx_q      <= '0;
         rd_q      <= '0;
         kill_q    <= 1'b0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cop_q     <= cop_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         sx_q      <= sx_d;
         rd_q      <= rd_d;
         kill_q    <= kill_d;
         rf_we_q   <= rf_we_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign l1d_req_val    = (state_q == S_REQ);
   assign l1d_req_addr   = addr_q;
   assign l1d_req_cop    = cop_q;
   assign l1d_req_size   = size_q;
   assign l1d_req_wdata  = wdata_q;
   assign wb2rf_we       = rf_we_q;
   assign wb2rf_rd       = rf_rd_q;
   assign wb2rf_data     = rf_data_q;
   assign wb2mem_bp_data = rf_data_q;
   assign wb2haz_stall   = ((state_q == S_IDLE) && wb_l1d_req_val_in
                            && !wb_kill)
                         || (state_q == S_REQ) || (state_q == S_RESP);

endmodule

// File: tb/tb_core_wb_s.sv
// Randomized bench for core_wb_s against a transaction-level model.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_core_wb_s;

   logic        clk;
   logic        rst_n;
   logic        wb_kill;
   logic        wb_l1d_req_val_in;
   logic [2:0]  wb_l1d_req_cop_in;
   logic [2:0]  wb_l1d_req_size_in;
   logic [31:0] wb_alu_result_in;
   logic [31:0] wb_wrt_data_in;
   logic [31:0] wb_sx_imm_in;
   logic [31:0] wb_pc_4_in;
   logic        wb_we_reg_file_in;
   logic [1:0]  wb_mux_in;
   logic [2:0]  wb_sx_type_in;
   logic [4:0]  wb_rd_in;
   logic        l1d_req_val;
   logic        l1d_req_ack;
   logic [31:0] l1d_req_addr;
   logic [2:0]  l1d_req_cop;
   logic [2:0]  l1d_req_size;
   logic [31:0] l1d_req_wdata;
   logic        l1d_resp_val;
   logic [31:0] l1d_resp_rdata;
   logic        wb2rf_we;
   logic [4:0]  wb2rf_rd;
   logic [31:0] wb2rf_data;
   logic [31:0] wb2mem_bp_data;
   logic        wb2haz_stall;

   int unsigned n_vec;
   int unsigned n_bad;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [2:0]  sxt [5];

   core_wb_s dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wb_kill            (wb_kill),
      .wb_l1d_req_val_in  (wb_l1d_req_val_in),
      .wb_l1d_req_cop_in  (wb_l1d_req_cop_in),
      .wb_l1d_req_size_in (wb_l1d_req_size_in),
      .wb_alu_result_in   (wb_alu_result_in),
      .wb_wrt_data_in     (wb_wrt_data_in),
      .wb_sx_imm_in       (wb_sx_imm_in),
      .wb_pc_4_in         (wb_pc_4_in),
      .wb_we_reg_file_in  (wb_we_reg_file_in),
      .wb_mux_in          (wb_mux_in),
      .wb_sx_type_in      (wb_sx_type_in),
      .wb_rd_in           (wb_rd_in),
      .l1d_req_val        (l1d_req_val),
      .l1d_req_ack        (l1d_req_ack),
      .l1d_req_addr       (l1d_req_addr),
      .l1d_req_cop        (l1d_req_cop),
      .l1d_req_size       (l1d_req_size),
      .l1d_req_wdata      (l1d_req_wdata),
      .l1d_resp_val       (l1d_resp_val),
      .l1d_resp_rdata     (l1d_resp_rdata),
      .wb2rf_we           (wb2rf_we),
      .wb2rf_rd           (wb2rf_rd),
      .wb2rf_data         (wb2rf_data),
      .wb2mem_bp_data     (wb2mem_bp_data),
      .wb2haz_stall       (wb2haz_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_repl(input logic [31:0] w,
                                            input logic [2:0] sz);
      if (sz == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w,
                                            input logic [1:0] off,
                                            input logic [2:0] sx);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (sx)
         3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4: return b;
         3'd5: return h;
         default: return w;
      endcase
   endfunction

   task automatic idle_inputs();
      wb_kill            = 1'b0;
      wb_l1d_req_val_in  = 1'b0;
      wb_we_reg_file_in  = 1'b0;
      l1d_req_ack        = 1'b0;
      l1d_resp_val       = 1'b0;
   endtask

   task automatic check_idle_after();
      @(negedge clk);
      check("pulse_we", wb2rf_we, 1'b0);
      check("hold_rd", wb2rf_rd, m_rd);
      check("hold_data", wb2rf_data, m_data);
      check("idle_stall", wb2haz_stall, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic alu_op(input logic [1:0] mux, input logic [31:0] alu,
                         input logic [31:0] imm, input logic [31:0] pc4,
                         input logic [4:0] rd, input bit we, input bit kill);
      logic [31:0] res;
      wb_l1d_req_val_in = 1'b0;
      wb_mux_in         = mux;
      wb_alu_result_in  = alu;
      wb_sx_imm_in      = imm;
      wb_pc_4_in        = pc4;
      wb_rd_in          = rd;
      wb_we_reg_file_in = we;
      wb_kill           = kill;
      @(negedge clk);
      check("alu_stall", wb2haz_stall, 1'b0);
      check("alu_rval", l1d_req_val, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
      res = (mux == 2'd0) ? alu : (mux == 2'd2) ? imm : pc4;
      if (we && !kill && rd != 0) begin
         m_rd   = rd;
         m_data = res;
      end
      @(negedge clk);
      check("alu_we", wb2rf_we, 32'(we && !kill && rd != 0));
      check("alu_rd", wb2rf_rd, m_rd);
      check("alu_data", wb2rf_data, m_data);
      check("alu_bp", wb2mem_bp_data, m_data);
      @(posedge clk); #1;
   endtask

   // mode: 0 plain, 1 kill in REQ without ack, 2 kill with ack,
   // 3 kill in first RESP cycle (loads only)
   task automatic mem_op(input bit st, input logic [2:0] sz,
                         input logic [2:0] sx, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [4:0] rd, input int ack_dly,
                         input int resp_dly, input int mode,
                         input bit cach);
      logic [2:0]  cop, rsz;
      logic [31:0] exp_wd;
      bit          exp_we;
      cop    = {cach, 1'b0, st};
      rsz    = st ? sz : {1'b0, sx[1:0]};
      exp_wd = ref_repl(wd, rsz);
      wb_l1d_req_val_in  = 1'b1;
      wb_l1d_req_cop_in  = cop;
      wb_l1d_req_size_in = rsz;
      wb_alu_result_in   = addr;
      wb_wrt_data_in     = wd;
      wb_sx_type_in      = sx;
      wb_rd_in           = rd;
      wb_we_reg_file_in  = 1'($urandom_range(0, 1));
      wb_mux_in          = 2'b01;
      wb_kill            = 1'b0;
      l1d_resp_rdata     = rdat;
      @(negedge clk);
      check("iss_stall", wb2haz_stall, 1'b1);
      check("iss_rval", l1d_req_val, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i <= ack_dly; i++) begin
         l1d_req_ack  = (i == ack_dly) && (mode != 1);
         wb_kill      = (i == ack_dly) && (mode == 1 || mode == 2);
         l1d_resp_val = (i < ack_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         check("req_val", l1d_req_val, 1'b1);
         check("req_addr", l1d_req_addr, addr);
         check("req_cop", l1d_req_cop, cop);
         check("req_size", l1d_req_size, rsz);
         check("req_wdata", l1d_req_wdata, exp_wd);
         check("req_stall", wb2haz_stall, 1'b1);
         @(posedge clk); #1;
      end
      l1d_req_ack  = 1'b0;
      wb_kill      = 1'b0;
      l1d_resp_val = 1'b0;
      if (mode == 1) begin
         idle_inputs();
         @(negedge clk);
         check("drop_rval", l1d_req_val, 1'b0);
         check("drop_we", wb2rf_we, 1'b0);
         @(posedge clk); #1;
         check_idle_after();
         return;
      end
      exp_we = 1'b0;
      if (!st) begin
         for (int j = 0; j <= resp_dly; j++) begin
            wb_kill      = (mode == 3) && (j == 0);
            l1d_resp_val = (j == resp_dly);
            @(negedge clk);
            check("resp_stall", wb2haz_stall, 1'b1);
            check("resp_rval", l1d_req_val, 1'b0);
            check("resp_we", wb2rf_we, 1'b0);
            @(posedge clk); #1;
         end
         exp_we = (mode == 0) && (rd != 0);
         if (exp_we) begin
            m_rd   = rd;
            m_data = ref_load(rdat, addr[1:0], sx);
         end
      end
      l1d_resp_val = 1'($urandom_range(0, 1));
      wb_kill      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_stall", wb2haz_stall, 1'b0);
      check("done_rval", l1d_req_val, 1'b0);
      check("done_we", wb2rf_we, 32'(exp_we));
      check("done_rd", wb2rf_rd, m_rd);
      check("done_data", wb2rf_data, m_data);
      check("done_bp", wb2mem_bp_data, m_data);
      @(posedge clk); #1;
      idle_inputs();
      check_idle_after();
   endtask

   task automatic reset_in_resp();
      wb_l1d_req_val_in  = 1'b1;
      wb_l1d_req_cop_in  = 3'b100;
      wb_l1d_req_size_in = 3'b010;
      wb_alu_result_in   = 32'h0000_0400;
      wb_sx_type_in      = 3'b010;
      wb_rd_in           = 5'd4;
      @(posedge clk); #1;
      l1d_req_ack = 1'b1;
      @(posedge clk); #1;
      l1d_req_ack = 1'b0;
      #2;
      rst_n = 1'b0;
      wb_l1d_req_val_in = 1'b0;
      #1;
      check("rst_stall", wb2haz_stall, 1'b0);
      check("rst_rval", l1d_req_val, 1'b0);
      check("rst_addr", l1d_req_addr, 32'h0);
      check("rst_cop", l1d_req_cop, 3'h0);
      check("rst_size", l1d_req_size, 3'h0);
      check("rst_wdata", l1d_req_wdata, 32'h0);
      check("rst_we", wb2rf_we, 1'b0);
      check("rst_rd", wb2rf_rd, 5'h0);
      check("rst_data", wb2rf_data, 32'h0);
      check("rst_bp", wb2mem_bp_data, 32'h0);
      m_rd   = '0;
      m_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      int      mode;
      bit      st;
      logic [1:0] mux;
      n_vec = 0;
      n_bad = 0;
      m_rd  = '0;
      m_data = '0;
      sxt[0] = 3'd0; sxt[1] = 3'd1; sxt[2] = 3'd2;
      sxt[3] = 3'd4; sxt[4] = 3'd5;
      rst_n              = 1'b0;
      wb_l1d_req_cop_in  = '0;
      wb_l1d_req_size_in = '0;
      wb_alu_result_in   = '0;
      wb_wrt_data_in     = '0;
      wb_sx_imm_in       = '0;
      wb_pc_4_in         = '0;
      wb_mux_in          = '0;
      wb_sx_type_in      = '0;
      wb_rd_in           = '0;
      l1d_resp_rdata     = '0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("init_stall", wb2haz_stall, 1'b0);
      check("init_rval", l1d_req_val, 1'b0);
      check("init_we", wb2rf_we, 1'b0);
      check("init_data", wb2rf_data, 32'h0);
      rst_n = 1'b1;

      alu_op(2'b00, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
      mem_op(1'b0, 3'd0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000,
             5'd7, 0, 1, 0, 1'b1);
      mem_op(1'b1, 3'd1, 3'd0, 32'h202, 32'h0000_ABCD, 32'h0,
             5'd9, 4, 0, 0, 1'b1);
      mem_op(1'b0, 3'd0, 3'd5, 32'h10E, 32'h0, 32'hF00F_0000,
             5'd3, 0, 1, 3, 1'b1);
      reset_in_resp();
      mem_op(1'b0, 3'd0, 3'd2, 32'h400, 32'h0, 32'hDEAD_BEEF,
             5'd0, 1, 0, 0, 1'b1);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            mux = 2'($urandom_range(0, 2));
            if (mux == 2'd1) mux = 2'd3;
            alu_op(mux, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) == 0));
         end else begin
            st   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 1) == 1) ? 0
                 : int'($urandom_range(1, st ? 2 : 3));
            mem_op(st, 3'($urandom_range(0, 2)), sxt[$urandom_range(0, 4)],
                   $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), mode, 1'($urandom_range(0, 1)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/core_wb_s.md
CORE_WB_S -- requirements
Module: core_wb_s

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset, as the ports below define.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wb_kill  in  1  flush of the instruction currently presented.
REQ-006 wb_l1d_req_val_in  in  1  instruction is a memory access.
REQ-007 wb_l1d_req_cop_in  in  3  bit2 cacheable; bits1:0 00 load, 01 store.
REQ-008 wb_l1d_req_size_in  in  3  000 byte, 001 half, 010 word.
REQ-009 wb_alu_result_in  in  32  ALU result; doubles as memory address.
REQ-010 wb_wrt_data_in  in  32  store data.
REQ-011 Upstream result inputs SHALL be: wb_sx_imm_in in 32; wb_pc_4_in in 32; wb_we_reg_file_in in 1; wb_mux_in in 2 (00 ALU, 01 load data, 10 imm, 11 pc+4); wb_sx_type_in in 3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); wb_rd_in in 5.
REQ-012 L1D request ports SHALL be: l1d_req_val out 1; l1d_req_ack in 1; l1d_req_addr out 32; l1d_req_cop out 3; l1d_req_size out 3; l1d_req_wdata out 32.
REQ-013 L1D response ports SHALL be: l1d_resp_val in 1; l1d_resp_rdata in 32.
REQ-014 Register-file and hazard ports SHALL be: wb2rf_we out 1; wb2rf_rd out 5; wb2rf_data out 32; wb2mem_bp_data out 32; wb2haz_stall out 1.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, RESP and DONE.
- IDLE, req_val_in=1, kill=0 -> REQ; request fields are captured into registers.
- REQ, ack=1 -> DONE for a store, RESP for a load.
- RESP, resp_val=1 -> DONE.
- DONE -> IDLE unconditionally.
REQ-016 l1d_req_val SHALL be 1 only in REQ; addr, cop, size and wdata SHALL hold their registered values stable until ack.
REQ-017 Store wdata SHALL be lane-replicated: byte -> {4{b}}; half -> {2{h}}; word unchanged.
REQ-018 wb2haz_stall SHALL equal (IDLE & req_val_in & !wb_kill) | REQ | RESP, and SHALL be 0 in DONE.
REQ-019 DONE SHALL ignore all inputs; this is the cycle in which upstream advances.
REQ-020 Non-memory instruction in IDLE: wb2rf_* SHALL update on the next edge with we = we_in & !kill & (rd!=0), and data selected by wb_mux_in.
REQ-021 Load write: on the edge after resp_val, wb2rf_we SHALL be 1 unless the load was killed or rd=0.
REQ-022 Load byte/half extraction SHALL use addr[1:0]; data SHALL be sign- or zero-extended per sx_type; misalignment is not checked.
REQ-023 wb2rf_we SHALL be a one-cycle pulse; wb2rf_rd and wb2rf_data SHALL hold until the next write.
REQ-024 wb2mem_bp_data SHALL equal wb2rf_data.
REQ-025 Minimum latency: load issue->rf write = 3 cycles with ack in REQ and resp the next cycle; store = 2 cycles.
REQ-026 l1d_resp_val SHALL be ignored outside RESP; a response in the same cycle as ack is illegal.
REQ-027 Kill in REQ with ack=0 SHALL drop the request and return to IDLE.
REQ-028 Kill in REQ with ack=1 SHALL count the request as issued: a store -> DONE; a load -> RESP with the write suppressed.
REQ-029 Kill in RESP SHALL keep waiting for the response and SHALL suppress the write.

Reset
REQ-030 Assertion of rst_n=0 SHALL force state to IDLE, all outputs to 0, and the kill-suppress flag to 0, regardless of clk.
REQ-031 Reset mid-transaction SHALL abandon the access; L1D is reset concurrently.

Structure
REQ-032 A shared package core_pkg SHALL hold the cop, size, sx_type and wb_mux encodings and the FSM state enum.
REQ-033 Load lane extraction and extension SHALL be a combinational sub-module, core_wb_ldext.

Verification
REQ-034 ALU op: mux=00, alu=0x1234, rd=5, we=1 -> next cycle rf_we=1, rd=5, data=0x1234; stall stays 0.
REQ-035 LB: addr=0x103, rdata=0x80FF_0000, ack in the first REQ cycle, resp 2 cycles later -> data=0xFFFF_FF80, stall high through RESP, DONE stall=0.
REQ-036 SH: addr=0x202, wdata=0x0000_ABCD, ack delayed 4 cycles -> l1d_req_wdata=0xABCD_ABCD held stable for 5 cycles, no rf write.
REQ-037 LHU killed in RESP: rdata=0xF00F_0000, addr[1]=1 -> FSM reaches DONE, rf_we stays 0.
REQ-038 rst_n low while in RESP -> outputs 0 immediately; after release a new LW to rd=0 issues the request and produces no rf write.
